// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, 16x sampling with majority vote,
// runtime data width/parity/stop configuration, break detection and a FWFT receive FIFO.
module uart_rx_os #(
   parameter int DATA_W     = 8,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   input  logic [DIV_W-1:0]  div,
   input  logic [3:0]        cfg_len,
   input  logic              cfg_par_en,
   input  logic              cfg_par_odd,
   input  logic              cfg_stop2,
   input  logic              rd_en,
   input  logic              clr_overrun,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_par_err,
   output logic              rd_frame_err,
   output logic              overrun,
   output logic              break_det,
   output logic              rx_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_W + 2;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_PARITY  = 3'd3;
   localparam logic [2:0] ST_STOP    = 3'd4;
   localparam logic [2:0] ST_STOP2   = 3'd5;
   localparam logic [2:0] ST_WAIT_HI = 3'd6;

   logic              rx_m;
   logic              rx_s;
   logic [DIV_W-1:0]  tick_cnt;
   logic              tick;
   logic [3:0]        s_cnt;
   logic [2:0]        state;
   logic [2:0]        state_next;
   logic              samp7;
   logic              samp8;
   logic              maj;
   logic              at_mid;
   logic              at_end;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] bit_mask;
   logic [3:0]        bit_cnt;
   logic              par_err_r;
   logic              frame_err_r;
   logic              par_zero_r;
   logic              brk_r;
   logic              stop_fe;
   logic              brk_now;
   logic              push;
   logic              push_fe;
   logic              push_brk;
   logic [EW-1:0]     push_word;

   logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              fifo_empty;
   logic              fifo_full;
   logic              do_rd;
   logic              do_wr;
   logic [EW-1:0]     head;

   assign tick     = (tick_cnt == '0);
   assign at_mid   = tick & (s_cnt == 4'd9);
   assign at_end   = tick & (s_cnt == 4'd15);
   assign maj      = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
   assign bit_mask = {{(DATA_W-1){1'b0}}, 1'b1} << bit_cnt;
   assign stop_fe  = frame_err_r | ~maj;
   // A break is an all-zero character whose first stop bit is also low.
   assign brk_now  = (shreg == '0) & par_zero_r & ~maj;
   assign push_word = {push_fe, par_err_r, shreg};

   // Input synchroniser and oversample tick generator.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m     <= 1'b1;
         rx_s     <= 1'b1;
         tick_cnt <= div;
      end else begin
         rx_m     <= rx;
         rx_s     <= rx_m;
         tick_cnt <= tick ? div : (tick_cnt - DIV_W'(1));
      end
   end

   // Next-state and push decision.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      push_fe    = frame_err_r;
      push_brk   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (tick & ~rx_s) state_next = ST_START;
            else              state_next = ST_IDLE;
         end
         ST_START: begin
            if (at_mid & maj) state_next = ST_IDLE;
            else if (at_end)  state_next = ST_DATA;
            else              state_next = ST_START;
         end
         ST_DATA: begin
            if (at_end && (bit_cnt == cfg_len)) state_next = cfg_par_en ? ST_PARITY : ST_STOP;
            else                                state_next = ST_DATA;
         end
         ST_PARITY: begin
            if (at_end) state_next = ST_STOP;
            else        state_next = ST_PARITY;
         end
         ST_STOP: begin
            if (at_mid & ~cfg_stop2) begin
               push       = 1'b1;
               push_fe    = stop_fe;
               push_brk   = brk_now;
               state_next = stop_fe ? ST_WAIT_HI : ST_IDLE;
            end else if (at_end & cfg_stop2) begin
               state_next = ST_STOP2;
            end else begin
               state_next = ST_STOP;
            end
         end
         ST_STOP2: begin
            if (at_mid) begin
               push       = 1'b1;
               push_fe    = stop_fe;
               push_brk   = brk_r;
               state_next = stop_fe ? ST_WAIT_HI : ST_IDLE;
            end else begin
               state_next = ST_STOP2;
            end
         end
         ST_WAIT_HI: begin
            if (tick & rx_s) state_next = ST_IDLE;
            else             state_next = ST_WAIT_HI;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Receiver state, sample counter and character assembly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         rx_busy     <= 1'b0;
         s_cnt       <= 4'd0;
         samp7       <= 1'b1;
         samp8       <= 1'b1;
         shreg       <= '0;
         bit_cnt     <= 4'd0;
         par_err_r   <= 1'b0;
         frame_err_r <= 1'b0;
         par_zero_r  <= 1'b1;
         brk_r       <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         state     <= state_next;
         rx_busy   <= (state_next != ST_IDLE);
         break_det <= push & push_brk;
         if (tick) begin
            if (state == ST_IDLE) s_cnt <= 4'd0;
            else                  s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd7) samp7 <= rx_s;
            if (s_cnt == 4'd8) samp8 <= rx_s;
         end
         if (state == ST_IDLE) begin
            shreg       <= '0;
            bit_cnt     <= 4'd0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            par_zero_r  <= 1'b1;
            brk_r       <= 1'b0;
         end else if (at_mid) begin
            case (state)
               ST_DATA: begin
                  shreg   <= maj ? (shreg | bit_mask) : shreg;
                  bit_cnt <= bit_cnt + 4'd1;
               end
               ST_PARITY: begin
                  par_err_r  <= (((^shreg) ^ maj) != cfg_par_odd);
                  par_zero_r <= ~maj;
               end
               ST_STOP: begin
                  frame_err_r <= stop_fe;
                  brk_r       <= brk_now;
               end
               ST_STOP2: frame_err_r <= stop_fe;
               default: ;
            endcase
         end
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd      = rd_en & ~fifo_empty;
   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign do_wr      = push & (~fifo_full | do_rd);

   // FIFO pointers and sticky overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push & fifo_full & ~rd_en) overrun <= 1'b1;
         else if (clr_overrun)          overrun <= 1'b0;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (do_wr) fifo_mem[wr_ptr[AW-1:0]] <= push_word;
   end

   // Head of FIFO presented combinationally, zero when empty.
   always_comb begin
      if (fifo_empty) head = '0;
      else            head = fifo_mem[rd_ptr[AW-1:0]];
   end

   assign rd_valid     = ~fifo_empty;
   assign rd_data      = head[DATA_W-1:0];
   assign rd_par_err   = head[DATA_W];
   assign rd_frame_err = head[DATA_W+1];

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: stimulus queues expected {frame_err, par_err, data}
// entries; a negedge monitor pops and compares whenever the FIFO presents data.
module tb_uart_rx_os;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic [15:0] div = 16'd0;
   logic [3:0]  cfg_len = 4'd8;
   logic        cfg_par_en = 1'b0;
   logic        cfg_par_odd = 1'b0;
   logic        cfg_stop2 = 1'b0;
   logic        mon_rd = 1'b0;
   logic        man_rd = 1'b0;
   logic        rd_en;
   logic        clr_overrun = 1'b0;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        rd_par_err;
   logic        rd_frame_err;
   logic        overrun;
   logic        break_det;
   logic        rx_busy;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          brk_cnt = 0;
   int          bt = 16;
   bit          auto_read = 1'b0;
   logic [9:0]  exp_q [$];

   assign rd_en = mon_rd | man_rd;

   uart_rx_os #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .rx(rx), .div(div), .cfg_len(cfg_len),
      .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
      .rd_en(rd_en), .clr_overrun(clr_overrun), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_par_err(rd_par_err), .rd_frame_err(rd_frame_err), .overrun(overrun),
      .break_det(break_det), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the FIFO head and compares against the scoreboard.
   always @(negedge clk) begin
      logic [9:0] e;
      mon_rd = 1'b0;
      if (auto_read && rd_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_entry: got %0h, expected none", {rd_frame_err, rd_par_err, rd_data});
         end else begin
            e = exp_q.pop_front();
            check("entry", {22'd0, rd_frame_err, rd_par_err, rd_data}, {22'd0, e});
         end
         mon_rd = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (break_det) brk_cnt++;
   end

   task automatic send_bit(input logic b);
      rx = b;
      repeat (bt) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int len, input logic par_en,
                             input logic par_bit, input logic stop1, input logic two_stop,
                             input logic stop2b);
      send_bit(1'b0);
      for (int i = 0; i < len; i++) send_bit(d[i]);
      if (par_en) send_bit(par_bit);
      send_bit(stop1);
      if (two_stop) send_bit(stop2b);
      rx = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic frame8(input logic [7:0] d);
      send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_flags", {rd_par_err, rd_frame_err, overrun, break_det, rx_busy}, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // 8N1 clean frame with push/busy latency at the stop-bit centre
      exp_q.push_back({2'b00, 8'hA5});
      fork
         frame8(8'hA5);
         begin
            repeat (156) @(negedge clk);
            check("8n1_busy_before", rx_busy, 1);
            check("8n1_valid_before", rd_valid, 0);
            @(negedge clk);
            check("8n1_valid_push", rd_valid, 1);
            check("8n1_busy_after", rx_busy, 0);
         end
      join
      auto_read = 1'b1;
      drain("8n1_drain");

      // False start: 5-clock low glitch
      auto_read = 1'b0;
      fork
         begin
            rx = 1'b0;
            repeat (5) @(negedge clk);
            rx = 1'b1;
         end
         begin
            repeat (12) @(negedge clk);
            check("false_start_busy", rx_busy, 1);
            @(negedge clk);
            check("false_start_idle", rx_busy, 0);
         end
      join
      repeat (200) @(negedge clk);
      check("false_start_no_push", rd_valid, 0);
      auto_read = 1'b1;

      // 7O2: good parity, bad parity, bad second stop bit (0x3C has four ones -> odd parity bit 1)
      cfg_len = 4'd7; cfg_par_en = 1'b1; cfg_par_odd = 1'b1; cfg_stop2 = 1'b1;
      exp_q.push_back({2'b00, 8'h3C});
      send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      exp_q.push_back({2'b01, 8'h3C});
      send_frame(8'h3C, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back({2'b10, 8'h3C});
      send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (40) @(negedge clk);
      drain("7o2_drain");

      // Break: 30 bit times low
      cfg_len = 4'd8; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
      brk_cnt = 0;
      exp_q.push_back({2'b10, 8'h00});
      rx = 1'b0;
      repeat (480) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      drain("break_drain");
      check("break_pulses", brk_cnt, 1);
      check("break_idle", rx_busy, 0);

      // Overrun: fifth character dropped
      auto_read = 1'b0;
      for (int i = 1; i <= 4; i++) exp_q.push_back({2'b00, 8'(i)});
      for (int i = 1; i <= 5; i++) frame8(8'(i));
      repeat (4) @(negedge clk);
      check("overrun_set", overrun, 1);
      check("overrun_head", rd_data, 8'h01);
      auto_read = 1'b1;
      drain("overrun_drain");
      check("overrun_sticky", overrun, 1);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      check("overrun_clear", overrun, 0);

      // Push coinciding with a read while full
      auto_read = 1'b0;
      for (int i = 0; i < 5; i++) exp_q.push_back({2'b00, 8'h11 + 8'(i)});
      for (int i = 0; i < 4; i++) frame8(8'h11 + 8'(i));
      fork
         frame8(8'h15);
         begin
            logic [9:0] e;
            repeat (156) @(negedge clk);
            check("full_before_push", rd_valid, 1);
            e = exp_q.pop_front();
            check("coincide_head", {22'd0, rd_frame_err, rd_par_err, rd_data}, {22'd0, e});
            man_rd = 1'b1;
            @(negedge clk);
            man_rd = 1'b0;
         end
      join
      check("coincide_no_overrun", overrun, 0);
      auto_read = 1'b1;
      drain("coincide_drain");

      // div=3: bit time 64 clocks
      div = 16'd3; bt = 64;
      exp_q.push_back({2'b00, 8'hC3});
      frame8(8'hC3);
      repeat (40) @(negedge clk);
      drain("div3_drain");
      div = 16'd0; bt = 16;
      repeat (10) @(negedge clk);

      // Reset during data bit 3, with a character already waiting in the FIFO
      auto_read = 1'b0;
      frame8(8'h77);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_valid", rd_valid, 0);
      check("midreset_data", rd_data, 0);
      check("midreset_flags", {overrun, break_det, rx_busy}, 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      auto_read = 1'b1;
      exp_q.push_back({2'b00, 8'h5A});
      frame8(8'h5A);
      repeat (20) @(negedge clk);
      drain("midreset_drain");
      check("final_empty", rd_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
